axi4_to_ahb: RTL and testbench
==============================

AXI4_TO_AHB -- requirements
Module: axi4_to_ahb

Interface
REQ-001 SHALL have parameter TAG, default 1, meaning AXI ID width.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- axi_awvalid/axi_awready  in/out  1  write address handshake
- axi_awid  in  TAG  write ID
- axi_awaddr  in  32  write address
- axi_awsize  in  3  write size
- axi_awlen  in  8  write length
- axi_wvalid/axi_wready  in/out  1  write data handshake
- axi_wdata  in  64  write data
- axi_wstrb  in  8  write strobes (not forwarded)
- axi_wlast  in  1  last beat
- axi_bvalid/axi_bready  out/in  1  write response handshake
- axi_bid  out  TAG  response ID
- axi_bresp  out  2  write response
- axi_arvalid/axi_arready  in/out  1  read address handshake
- axi_arid  in  TAG  read ID
- axi_araddr  in  32  read address
- axi_arsize  in  3  read size
- axi_arlen  in  8  read length
- axi_rvalid/axi_rready  out/in  1  read data handshake
- axi_rid  out  TAG  read ID
- axi_rdata  out  64  read data
- axi_rresp  out  2  read response
- axi_rlast  out  1  last beat, tied 1
- ahb_haddr  out  32  address
- ahb_hsize  out  3  size
- ahb_htrans  out  2  transfer type, 2'b00 or 2'b10 only
- ahb_hwrite  out  1  write
- ahb_hwdata  out  64  write data
- ahb_hburst  out  3  tied 0
- ahb_hmastlock  out  1  tied 0
- ahb_hprot  out  4  tied 4'b0011
- ahb_hrdata  in  64  read data
- ahb_hready  in  1  transfer done
- ahb_hresp  in  1  error

Function
REQ-004 SHALL allow one outstanding transaction; FSM states IDLE, ADDR, DATA, RESP.
REQ-005 IDLE, write candidate: awvalid & wvalid both high; read candidate: arvalid high.
REQ-006 Both candidates present: a one-bit round-robin pointer SHALL choose; the pointer resets to write-first and toggles after each accepted transaction.
REQ-007 Write accept SHALL assert awready and wready together for one cycle, never one without the other; read accept SHALL assert arready for one cycle; all readies SHALL be 0 outside IDLE.
REQ-008 On accept, SHALL capture addr, size, ID, direction and wdata.
- awlen/arlen != 0: SHALL skip AHB, set error flag, go directly to RESP.
- Otherwise: go to ADDR.
REQ-009 ADDR SHALL drive htrans=2'b10, haddr, hsize={1'b0,size[1:0]} and hwrite; ahb_hready=1 -> DATA, else hold.
REQ-010 DATA SHALL drive htrans=2'b00 and hwdata (writes); it SHALL exit to RESP on ahb_hready=1.
- At exit, SHALL capture hrdata for reads.
- At exit, SHALL capture error = ahb_hresp.
- hresp=1 with hready=0 (first error cycle) SHALL hold DATA.
REQ-011 RESP SHALL assert bvalid (write) or rvalid (read).
- bresp/rresp = 2'b10 on error, else 2'b00.
- bid/rid = captured ID.
- rdata = captured hrdata.
- Outputs SHALL be held stable until bready/rready, then go to IDLE.
REQ-012 Latency with zero-wait AHB: accept at edge N; htrans=NONSEQ in cycle N+1; data phase N+2; valid in cycle N+3. Next accept no earlier than the cycle after the response handshake.
REQ-013 htrans SHALL be 2'b00 in every state except ADDR.
REQ-014 Unaligned addresses SHALL be forwarded unchanged; the AHB slave owns the error decision.

Reset
REQ-015 rst=1 SHALL force IDLE and clear the error flag and round-robin pointer (write-first).
REQ-016 rst=1 SHALL force all valid/ready outputs to 0, htrans=2'b00, and captured addr/data/ID to 0.
REQ-017 Reset mid-transaction SHALL abandon it with no AXI response issued; the first cycle after reset deassertion SHALL show IDLE outputs.

Verification
REQ-018 Write addr 0x1000_0008, size 3, wdata 0xDEADBEEF_01234567, hready=1 always -> htrans=2'b10 one cycle later, then hwdata=0xDEADBEEF_01234567, then bvalid with bresp=2'b00, bid=awid.
REQ-019 Read addr 0x2000_0004, size 2, hrdata=0x0000_0000_CAFEF00D, 2 hready wait cycles in data phase -> rvalid 5 cycles after arready, rdata=0xCAFEF00D, rresp=2'b00, rlast=1.
REQ-020 AHB two-cycle error (hresp=1/hready=0 then hresp=1/hready=1) on read -> rresp=2'b10; no hang; next transaction accepted.
REQ-021 awvalid, wvalid and arvalid asserted simultaneously from reset -> write served first, then read; awvalid without wvalid -> no awready.
REQ-022 arlen=3 -> no htrans=2'b10 issued; rresp=2'b10, rvalid 1 cycle after accept.
REQ-023 rst pulsed during DATA -> next cycle all valids 0 and htrans=2'b00; a fresh read completes normally.

Source files
------------

// File: rtl/axi4_to_ahb.sv
// -----------------------------------------------------------------------------
// axi4_to_ahb
//
// Single-outstanding bridge from an AXI4 slave port to an AHB-Lite master port.
// Only single-beat AXI bursts (len == 0) are carried to AHB; longer bursts are
// answered with SLVERR without touching the bus. Every AHB access is one
// NONSEQ transfer followed by an IDLE cycle, so HBURST is always SINGLE.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   axi_aw*/axi_w*           write address + data (accepted together)
//   axi_b*                   write response
//   axi_ar*                  read address
//   axi_r*                   read data/response (rlast always 1)
//   ahb_h* (outputs)         AHB-Lite master address/data/control
//   ahb_hrdata/hready/hresp  AHB-Lite slave response
// -----------------------------------------------------------------------------
module axi4_to_ahb #(
    parameter int TAG = 1
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           axi_awvalid,
    output logic           axi_awready,
    input  logic [TAG-1:0] axi_awid,
    input  logic [31:0]    axi_awaddr,
    input  logic [2:0]     axi_awsize,
    input  logic [7:0]     axi_awlen,
    input  logic           axi_wvalid,
    output logic           axi_wready,
    input  logic [63:0]    axi_wdata,
    input  logic [7:0]     axi_wstrb,
    input  logic           axi_wlast,
    output logic           axi_bvalid,
    input  logic           axi_bready,
    output logic [TAG-1:0] axi_bid,
    output logic [1:0]     axi_bresp,

    input  logic           axi_arvalid,
    output logic           axi_arready,
    input  logic [TAG-1:0] axi_arid,
    input  logic [31:0]    axi_araddr,
    input  logic [2:0]     axi_arsize,
    input  logic [7:0]     axi_arlen,
    output logic           axi_rvalid,
    input  logic           axi_rready,
    output logic [TAG-1:0] axi_rid,
    output logic [63:0]    axi_rdata,
    output logic [1:0]     axi_rresp,
    output logic           axi_rlast,

    output logic [31:0]    ahb_haddr,
    output logic [2:0]     ahb_hsize,
    output logic [1:0]     ahb_htrans,
    output logic           ahb_hwrite,
    output logic [63:0]    ahb_hwdata,
    output logic [2:0]     ahb_hburst,
    output logic           ahb_hmastlock,
    output logic [3:0]     ahb_hprot,
    input  logic [63:0]    ahb_hrdata,
    input  logic           ahb_hready,
    input  logic           ahb_hresp
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;          // 0: write wins a tie, 1: read wins
    logic           err_q, err_d;
    logic           write_q, write_d;
    logic [31:0]    addr_q, addr_d;
    logic [1:0]     size_q, size_d;      // AHB HSIZE carries at most 64-bit
    logic [TAG-1:0] id_q, id_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [63:0]    rdata_q, rdata_d;

    logic wr_cand, rd_cand, take_wr, take_rd, len_nz;

    // Byte strobes are not forwarded (AHB-Lite has none) and every accepted
    // write is a single beat, so wlast and the top size bit carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{axi_wstrb, axi_wlast, axi_awsize[2], axi_arsize[2]};

    // A write needs both address and data present; it is never accepted
    // piecemeal, which keeps awready and wready identical.
    assign wr_cand = axi_awvalid & axi_wvalid;
    assign rd_cand = axi_arvalid;
    assign take_wr = wr_cand & (~rd_cand | ~rr_q);
    assign take_rd = rd_cand & ~take_wr;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        rr_d        = rr_q;
        err_d       = err_q;
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        id_d        = id_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        len_nz      = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_arready = 1'b0;
        axi_bvalid  = 1'b0;
        axi_rvalid  = 1'b0;
        ahb_htrans  = HTRANS_IDLE;
        ahb_hwrite  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (take_wr) begin
                    axi_awready = 1'b1;
                    axi_wready  = 1'b1;
                    write_d     = 1'b1;
                    addr_d      = axi_awaddr;
                    size_d      = axi_awsize[1:0];
                    id_d        = axi_awid;
                    wdata_d     = axi_wdata;
                    len_nz      = |axi_awlen;
                end else if (take_rd) begin
                    axi_arready = 1'b1;
                    write_d     = 1'b0;
                    addr_d      = axi_araddr;
                    size_d      = axi_arsize[1:0];
                    id_d        = axi_arid;
                    len_nz      = |axi_arlen;
                end
                if (take_wr | take_rd) begin
                    rr_d    = ~rr_q;
                    // Multi-beat bursts are refused outright and never reach AHB.
                    err_d   = len_nz;
                    state_d = len_nz ? RESP : ADDR;
                end
            end
            ADDR: begin
                ahb_htrans = HTRANS_NONSEQ;
                ahb_hwrite = write_q;
                if (ahb_hready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // The first cycle of a two-cycle error response has hready low
                // and simply extends the data phase; the error is taken only
                // when the transfer completes.
                if (ahb_hready) begin
                    err_d   = ahb_hresp;
                    state_d = RESP;
                    if (!write_q) begin
                        rdata_d = ahb_hrdata;
                    end
                end
            end
            RESP: begin
                axi_bvalid = write_q;
                axi_rvalid = ~write_q;
                if (write_q ? axi_bready : axi_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            id_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            id_q    <= id_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured values are driven continuously; htrans/hwrite/valid qualify them.
    assign ahb_haddr     = addr_q;
    assign ahb_hsize     = {1'b0, size_q};
    assign ahb_hwdata    = wdata_q;
    assign ahb_hburst    = 3'b000;
    assign ahb_hmastlock = 1'b0;
    assign ahb_hprot     = 4'b0011;

    assign axi_bid   = id_q;
    assign axi_rid   = id_q;
    assign axi_bresp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rdata = rdata_q;
    assign axi_rlast = 1'b1;

endmodule

// File: tb/tb_axi4_to_ahb.sv
// -----------------------------------------------------------------------------
// tb_axi4_to_ahb
//
// Scoreboard bench for axi4_to_ahb. Stimulus tasks push the expected AXI
// response (and, for bus-reaching transfers, the AHB slave's plan) when the
// bridge accepts a request; an AHB slave model replays the plan and checks the
// address/data phases; a response monitor compares every presented response
// against the head of the expectation queue.
// -----------------------------------------------------------------------------
module tb_axi4_to_ahb;

    localparam int TAG = 4;

    logic           clk;
    logic           rst;
    logic           axi_awvalid, axi_awready;
    logic [TAG-1:0] axi_awid;
    logic [31:0]    axi_awaddr;
    logic [2:0]     axi_awsize;
    logic [7:0]     axi_awlen;
    logic           axi_wvalid, axi_wready;
    logic [63:0]    axi_wdata;
    logic [7:0]     axi_wstrb;
    logic           axi_wlast;
    logic           axi_bvalid, axi_bready;
    logic [TAG-1:0] axi_bid;
    logic [1:0]     axi_bresp;
    logic           axi_arvalid, axi_arready;
    logic [TAG-1:0] axi_arid;
    logic [31:0]    axi_araddr;
    logic [2:0]     axi_arsize;
    logic [7:0]     axi_arlen;
    logic           axi_rvalid, axi_rready;
    logic [TAG-1:0] axi_rid;
    logic [63:0]    axi_rdata;
    logic [1:0]     axi_rresp;
    logic           axi_rlast;
    logic [31:0]    ahb_haddr;
    logic [2:0]     ahb_hsize;
    logic [1:0]     ahb_htrans;
    logic           ahb_hwrite;
    logic [63:0]    ahb_hwdata;
    logic [2:0]     ahb_hburst;
    logic           ahb_hmastlock;
    logic [3:0]     ahb_hprot;
    logic [63:0]    ahb_hrdata;
    logic           ahb_hready;
    logic           ahb_hresp;

    axi4_to_ahb #(.TAG(TAG)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans),
        .ahb_hwrite(ahb_hwrite), .ahb_hwdata(ahb_hwdata), .ahb_hburst(ahb_hburst),
        .ahb_hmastlock(ahb_hmastlock), .ahb_hprot(ahb_hprot),
        .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One AXI request plus the AHB slave behaviour planned for it.
    typedef struct {
        bit             wr;
        logic [TAG-1:0] id;
        logic [31:0]    addr;
        logic [2:0]     size;
        logic [7:0]     len;
        logic [63:0]    data;   // write data, or read data the slave returns
        int             aw;     // hready-low cycles in the address phase
        int             dw;     // hready-low cycles in the data phase (OKAY)
        bit             err;    // finish with a two-cycle ERROR response
        int             acc;    // cycle the request was accepted
    } txn_t;

    typedef struct {
        bit             wr;
        logic [TAG-1:0] id;
        logic [1:0]     resp;
        logic [63:0]    rdata;
        bit             chk_rdata;
        int             lat;
        int             acc;
    } exp_t;

    txn_t pq[$];
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit rr_model = 1'b0;   // 0: write is next to win a tie
    bit slave_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic txn_t mk(input bit wr, input logic [TAG-1:0] id, input logic [31:0] addr,
                                input logic [2:0] size, input logic [7:0] len, input logic [63:0] data,
                                input int aw, input int dw, input bit err);
        txn_t t;
        t.wr = wr; t.id = id; t.addr = addr; t.size = size; t.len = len; t.data = data;
        t.aw = aw; t.dw = dw; t.err = err; t.acc = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit wr);
        logic [7:0] len;
        len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        return mk(wr, TAG'($urandom), $urandom, 3'($urandom_range(0, 7)), len,
                  {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0);
    endfunction

    // Reference model of what one accepted request must produce.
    task automatic accept(input txn_t t_in);
        txn_t t;
        exp_t e;
        t = t_in;
        t.acc = cyc;
        e.wr = t.wr; e.id = t.id; e.acc = cyc;
        if (t.len != 0) begin
            e.resp = 2'b10; e.lat = 1; e.chk_rdata = 1'b0; e.rdata = '0;
        end else begin
            pq.push_back(t);
            e.resp = t.err ? 2'b10 : 2'b00;
            e.lat = 3 + t.aw + t.dw + (t.err ? 1 : 0);
            e.chk_rdata = !t.wr;
            e.rdata = t.data;
        end
        exp_q.push_back(e);
        rr_model = ~rr_model;
    endtask

    // Present a write and/or a read; hold each until accepted.
    task automatic issue(input bit use_w, input txn_t w, input bit use_r, input txn_t r);
        bit pw, pr;
        pw = use_w; pr = use_r;
        if (use_w) begin
            axi_awid = w.id; axi_awaddr = w.addr; axi_awsize = w.size; axi_awlen = w.len;
            axi_wdata = w.data; axi_wstrb = 8'($urandom); axi_wlast = 1'b1;
            axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        end
        if (use_r) begin
            axi_arid = r.id; axi_araddr = r.addr; axi_arsize = r.size; axi_arlen = r.len;
            axi_arvalid = 1'b1;
        end
        for (int k = 0; k < 300 && (pw || pr); k++) begin
            @(negedge clk);
            if (pw && axi_awready && axi_wready) begin
                if (pr) check("tie_winner(0=wr)", 64'd0, 64'(rr_model));
                accept(w); pw = 1'b0;
            end else if (pr && axi_arready) begin
                if (pw) check("tie_winner(0=wr)", 64'd1, 64'(rr_model));
                accept(r); pr = 1'b0;
            end
            @(posedge clk); #1;
            if (!pw) begin axi_awvalid = 1'b0; axi_wvalid = 1'b0; end
            if (!pr) axi_arvalid = 1'b0;
        end
        if (pw || pr) begin
            check("accept_timeout", 64'(pw || pr), 64'd0);
            axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // AHB slave: replays the plan of each accepted bus-reaching request.
    initial begin
        txn_t p;
        ahb_hready = 1'b1; ahb_hresp = 1'b0; ahb_hrdata = '0;
        forever begin
            @(negedge clk);
            if (slave_en && !rst && ahb_htrans == 2'b10) begin
                if (pq.size() == 0) begin
                    check("unexpected_nonseq", 64'(ahb_htrans), 64'd0);
                end else begin
                    p = pq.pop_front();
                    check("nonseq_delay", 64'(cyc - p.acc), 64'd1);
                    check("haddr", 64'(ahb_haddr), 64'(p.addr));
                    check("hsize", 64'(ahb_hsize), 64'({1'b0, p.size[1:0]}));
                    check("hwrite", 64'(ahb_hwrite), 64'(p.wr));
                    for (int k = 0; k < p.aw; k++) begin
                        ahb_hready = 1'b0;
                        @(negedge clk);
                        check("addr_hold", 64'(ahb_htrans), 64'd2);
                    end
                    ahb_hready = 1'b1;
                    @(negedge clk);
                    check("data_phase_htrans", 64'(ahb_htrans), 64'd0);
                    if (p.wr) check("hwdata", ahb_hwdata, p.data);
                    for (int k = 0; k < p.dw; k++) begin
                        ahb_hready = 1'b0; ahb_hresp = 1'b0; ahb_hrdata = {$urandom, $urandom};
                        @(negedge clk);
                    end
                    if (p.err) begin
                        ahb_hready = 1'b0; ahb_hresp = 1'b1;
                        @(negedge clk);
                    end
                    ahb_hready = 1'b1; ahb_hresp = p.err; ahb_hrdata = p.data;
                    @(negedge clk);
                    ahb_hresp = 1'b0; ahb_hrdata = {$urandom, $urandom};
                end
            end
        end
    end

    // Response and protocol monitor.
    initial begin
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                check("awready_eq_wready", 64'(axi_awready), 64'(axi_wready));
                check("htrans_legal", 64'(ahb_htrans == 2'b00 || ahb_htrans == 2'b10), 64'd1);
                if (axi_awready) check("awready_needs_aw_w", 64'(axi_awvalid && axi_wvalid), 64'd1);
                if (axi_arready) check("arready_excl", 64'(axi_awready), 64'd0);
                if (axi_bvalid || axi_rvalid) begin
                    check("one_valid", 64'(axi_bvalid && axi_rvalid), 64'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 64'(axi_bvalid || axi_rvalid), 64'd0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_v) check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
                        check("resp_is_write", 64'(axi_bvalid), 64'(e.wr));
                        if (e.wr) begin
                            check("bid", 64'(axi_bid), 64'(e.id));
                            check("bresp", 64'(axi_bresp), 64'(e.resp));
                        end else begin
                            check("rid", 64'(axi_rid), 64'(e.id));
                            check("rresp", 64'(axi_rresp), 64'(e.resp));
                            check("rlast", 64'(axi_rlast), 64'd1);
                            if (e.chk_rdata) check("rdata", axi_rdata, e.rdata);
                        end
                        if ((axi_bvalid && axi_bready) || (axi_rvalid && axi_rready))
                            void'(exp_q.pop_front());
                    end
                end
                prev_v = axi_bvalid || axi_rvalid;
            end
        end
    end

    // Randomly back-pressured response channels.
    initial begin
        axi_bready = 1'b0; axi_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            axi_bready = $urandom_range(0, 2) != 0;
            axi_rready = $urandom_range(0, 2) != 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    txn_t none;

    initial begin
        rst = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
        axi_awid = '0; axi_awaddr = '0; axi_awsize = '0; axi_awlen = '0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b1;
        axi_arid = '0; axi_araddr = '0; axi_arsize = '0; axi_arlen = '0;
        none = mk(1'b0, '0, '0, '0, '0, '0, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(axi_awready), 64'd0);
        check("rst_arready", 64'(axi_arready), 64'd0);
        check("rst_bvalid", 64'(axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(axi_rvalid), 64'd0);
        check("rst_htrans", 64'(ahb_htrans), 64'd0);
        check("rst_haddr", 64'(ahb_haddr), 64'd0);
        check("rst_hwdata", ahb_hwdata, 64'd0);
        check("rst_rid", 64'(axi_rid), 64'd0);
        check("tie_hburst", 64'(ahb_hburst), 64'd0);
        check("tie_hmastlock", 64'(ahb_hmastlock), 64'd0);
        check("tie_hprot", 64'(ahb_hprot), 64'h3);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous write and read right after reset: write first.
        issue(1'b1, mk(1'b1, 4'h5, 32'h1000_0008, 3'd3, 8'd0, 64'hDEADBEEF_01234567, 0, 0, 1'b0),
              1'b1, mk(1'b0, 4'hA, 32'h2000_0004, 3'd2, 8'd0, 64'h0000_0000_CAFEF00D, 0, 2, 1'b0));
        wait_idle();

        // Address without write data must not be accepted.
        axi_awvalid = 1'b1; axi_wvalid = 1'b0; axi_awaddr = 32'h3000_0000;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (axi_awready) seen++;
            end
            check("aw_without_w_accepted", 64'(seen), 64'd0);
        end
        @(posedge clk); #1;
        axi_awvalid = 1'b0;

        // Two-cycle AHB error on a read, then a normal write.
        issue(1'b0, none, 1'b1, mk(1'b0, 4'h3, 32'h4000_0010, 3'd3, 8'd0, 64'h1111_2222_3333_4444, 1, 0, 1'b1));
        issue(1'b1, mk(1'b1, 4'h7, 32'h4000_0003, 3'd0, 8'd0, 64'h5555_6666_7777_8888, 0, 1, 1'b0), 1'b0, none);
        wait_idle();

        // Burst read is refused without an AHB transfer.
        issue(1'b0, none, 1'b1, mk(1'b0, 4'h9, 32'h5000_0000, 3'd3, 8'd3, 64'd0, 0, 0, 1'b0));
        wait_idle();

        // Reset while the data phase is stalled.
        slave_en = 1'b0;
        issue(1'b0, none, 1'b1, mk(1'b0, 4'h2, 32'h6000_0000, 3'd3, 8'd0, 64'd0, 0, 0, 1'b0));
        @(posedge clk); #1;
        ahb_hready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pq.delete(); exp_q.delete(); rr_model = 1'b0;
        @(negedge clk);
        check("post_rst_bvalid", 64'(axi_bvalid), 64'd0);
        check("post_rst_rvalid", 64'(axi_rvalid), 64'd0);
        check("post_rst_arready", 64'(axi_arready), 64'd0);
        check("post_rst_htrans", 64'(ahb_htrans), 64'd0);
        check("post_rst_haddr", 64'(ahb_haddr), 64'd0);
        ahb_hready = 1'b1;
        slave_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, none, 1'b1, mk(1'b0, 4'h4, 32'h6000_0008, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0));
        wait_idle();

        // Randomised mix of writes, reads and ties.
        for (int i = 0; i < 60; i++) begin
            txn_t a, b;
            int   mode;
            a = rand_txn(1'b1);
            b = rand_txn(1'b0);
            mode = $urandom_range(0, 2);
            issue(mode != 1, a, mode != 0, b);
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
